sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO for the byte and word datapaths between producer and consumer blocks, succeeding the fixed 8-bit × 256 FIFO. Adds:
- configurable width and depth;
- a full-range occupancy count that does not wrap at full;
- programmable almost-full and almost-empty flags;
- a show-ahead read mode;
- a synchronous clear;
- overflow and underflow error pulses.

---
 rtl/sync_fifo_param.sv | 114 +++++++++++
 tb/tb_sync_fifo_param.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// optional show-ahead read port, synchronous clear and overflow/underflow pulses.
module sync_fifo_param #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 8,
   parameter int AFULL_TH   = 240,
   parameter int AEMPTY_TH  = 16,
   parameter int SHOW_AHEAD = 0
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              sclr,
   input  logic [DATA_W-1:0] data,
   input  logic              wrreq,
   input  logic              rdreq,
   output logic [DATA_W-1:0] q,
   output logic              empty,
   output logic              full,
   output logic              almost_empty,
   output logic              almost_full,
   output logic [ADDR_W:0]   usedw,
   output logic              overflow,
   output logic              underflow
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   AF_LVL   = (ADDR_W+1)'(AFULL_TH);
   localparam logic [ADDR_W:0]   AE_LVL   = (ADDR_W+1)'(AEMPTY_TH);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic [ADDR_W:0]   count_nxt;
   logic              wr_ok;
   logic              rd_ok;

   // Handshake: wrreq/rdreq are requests sampled on the rising edge. A write is
   // taken only when full is low and a read only when empty is low (flags as
   // registered before that edge); a rejected request raises overflow/underflow
   // for the following cycle. sclr wins over both requests.
   assign wr_ok = wrreq & ~full;
   assign rd_ok = rdreq & ~empty;
   assign usedw = count;

   always_comb begin
      count_nxt = count;
      if (sclr)
         count_nxt = '0;
      else if (wr_ok && !rd_ok)
         count_nxt = count + CNT_ONE;
      else if (rd_ok && !wr_ok)
         count_nxt = count - CNT_ONE;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         // Flags come from the next count so they move on the same edge as usedw.
         count        <= count_nxt;
         empty        <= (count_nxt == '0);
         full         <= (count_nxt == CNT_FULL);
         almost_empty <= (count_nxt <= AE_LVL);
         almost_full  <= (count_nxt >= AF_LVL);
         if (sclr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
            overflow  <= wrreq & full;
            underflow <= rdreq & empty;
         end
      end
   end

   // Storage is never cleared; only the pointers reset.
   always_ff @(posedge sys_clk) begin
      if (wr_ok && !sclr && !sys_rst)
         mem[wr_ptr] <= data;
   end

   generate
      if (SHOW_AHEAD != 0) begin : g_show_ahead
         assign q = mem[rd_ptr];
      end else begin : g_normal
         logic [DATA_W-1:0] q_reg;
         always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst)
               q_reg <= '0;
            else if (sclr)
               q_reg <= '0;
            else if (rd_ok)
               q_reg <= mem[rd_ptr];
         end
         assign q = q_reg;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a normal-mode and a show-ahead instance share all
// inputs; a queue model tracks contents, occupancy, read data and error pulses.
module tb_sync_fifo_param;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int DEPTH = 16;
   localparam int AF = 14;
   localparam int AE = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sclr = 1'b0;
   logic          wrreq = 1'b0;
   logic          rdreq = 1'b0;
   logic [DW-1:0] data = '0;

   logic [DW-1:0] q, q_sa;
   logic          empty, full, almost_empty, almost_full, overflow, underflow;
   logic          empty_sa, full_sa, almost_empty_sa, almost_full_sa, overflow_sa, underflow_sa;
   logic [AW:0]   usedw, usedw_sa;
   logic [5:0]    flags, flags_sa;

   assign flags    = {empty, full, almost_empty, almost_full, overflow, underflow};
   assign flags_sa = {empty_sa, full_sa, almost_empty_sa, almost_full_sa, overflow_sa, underflow_sa};

   int total = 0;
   int bad = 0;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] q_exp = '0;
   logic          ovf_exp = 1'b0;
   logic          udf_exp = 1'b0;

   sync_fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AFULL_TH(AF), .AEMPTY_TH(AE), .SHOW_AHEAD(0)) dut (
      .sys_clk(clk), .sys_rst(rst), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
      .q(q), .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
      .usedw(usedw), .overflow(overflow), .underflow(underflow));

   sync_fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AFULL_TH(AF), .AEMPTY_TH(AE), .SHOW_AHEAD(1)) dut_sa (
      .sys_clk(clk), .sys_rst(rst), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
      .q(q_sa), .empty(empty_sa), .full(full_sa), .almost_empty(almost_empty_sa),
      .almost_full(almost_full_sa), .usedw(usedw_sa), .overflow(overflow_sa), .underflow(underflow_sa));

   // clock / reset
   always #5 clk = ~clk;

   // Expected status word {empty, full, almost_empty, almost_full, overflow, underflow}.
   function automatic logic [5:0] flags_for(input int n, input logic ov, input logic ud);
      return {n == 0, n == DEPTH, n <= AE, n >= AF, ov, ud};
   endfunction

   function automatic void model_clear();
      exp_q.delete();
      q_exp   = '0;
      ovf_exp = 1'b0;
      udf_exp = 1'b0;
   endfunction

   // Driver: apply one cycle of inputs at the falling edge, update the model at
   // the rising edge, return at the next falling edge for sampling.
   task automatic step(input logic w, input logic r, input logic clr, input logic [DW-1:0] d);
      bit wr_ok, rd_ok;
      wrreq = w; rdreq = r; sclr = clr; data = d;
      @(posedge clk);
      wr_ok = w && (exp_q.size() < DEPTH);
      rd_ok = r && (exp_q.size() > 0);
      if (clr) begin
         model_clear();
      end else begin
         ovf_exp = w && !wr_ok;
         udf_exp = r && !rd_ok;
         if (rd_ok) q_exp = exp_q.pop_front();
         if (wr_ok) exp_q.push_back(d);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (usedw !== 5'd0) begin bad++; $display("FAIL reset_usedw got=%0d want=0", usedw); end
      total++; if (flags !== 6'b101000) begin bad++; $display("FAIL reset_flags got=%b want=101000", flags); end
      total++; if (q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h want=00", q); end
      rst = 1'b0;
      model_clear();
      step(1'b0, 1'b0, 1'b0, 8'h00);
      total++; if (flags_sa !== 6'b101000) begin bad++; $display("FAIL reset_flags_sa got=%b want=101000", flags_sa); end
   endtask

   task automatic test_fill_drain();
      for (int k = 1; k <= DEPTH; k++) begin
         step(1'b1, 1'b0, 1'b0, DW'(k - 1));
         total++; if (usedw !== 5'(k)) begin bad++; $display("FAIL fill_usedw k=%0d got=%0d want=%0d", k, usedw, k); end
         total++; if (flags !== flags_for(k, 1'b0, 1'b0)) begin bad++; $display("FAIL fill_flags k=%0d got=%b want=%b", k, flags, flags_for(k, 1'b0, 1'b0)); end
      end
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 1'b1, 1'b0, 8'h00);
         total++; if (q !== DW'(i)) begin bad++; $display("FAIL drain_q i=%0d got=%h want=%h", i, q, DW'(i)); end
         total++; if (usedw !== 5'(DEPTH - 1 - i)) begin bad++; $display("FAIL drain_usedw i=%0d got=%0d want=%0d", i, usedw, DEPTH - 1 - i); end
         total++; if (flags !== flags_for(DEPTH - 1 - i, 1'b0, 1'b0)) begin bad++; $display("FAIL drain_flags i=%0d got=%b want=%b", i, flags, flags_for(DEPTH - 1 - i, 1'b0, 1'b0)); end
      end
   endtask

   task automatic test_overflow_underflow();
      for (int k = 0; k < DEPTH; k++) step(1'b1, 1'b0, 1'b0, DW'(k));
      step(1'b1, 1'b0, 1'b0, 8'hEE);
      total++; if (usedw !== 5'd16) begin bad++; $display("FAIL ovf_usedw got=%0d want=16", usedw); end
      total++; if (flags !== 6'b010110) begin bad++; $display("FAIL ovf_flags got=%b want=010110", flags); end
      step(1'b0, 1'b0, 1'b0, 8'h00);
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_pulse_len got=%b want=0", overflow); end
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 1'b1, 1'b0, 8'h00);
         total++; if (q !== DW'(i)) begin bad++; $display("FAIL ovf_read i=%0d got=%h want=%h", i, q, DW'(i)); end
      end
      step(1'b0, 1'b1, 1'b0, 8'h00);
      total++; if (flags !== 6'b101001) begin bad++; $display("FAIL udf_flags got=%b want=101001", flags); end
      total++; if (q !== 8'h0F) begin bad++; $display("FAIL udf_q_hold got=%h want=0f", q); end
      step(1'b0, 1'b0, 1'b0, 8'h00);
      total++; if (underflow !== 1'b0) begin bad++; $display("FAIL udf_pulse_len got=%b want=0", underflow); end
   endtask

   task automatic test_simultaneous();
      logic [DW-1:0] lq[$];
      logic [DW-1:0] want;
      for (int k = 0; k < DEPTH; k++) step(1'b1, 1'b0, 1'b0, DW'(8'h10 + k));
      step(1'b1, 1'b1, 1'b0, 8'h99);
      total++; if (usedw !== 5'd15) begin bad++; $display("FAIL both_full_usedw got=%0d want=15", usedw); end
      total++; if (flags !== 6'b000110) begin bad++; $display("FAIL both_full_flags got=%b want=000110", flags); end
      total++; if (q !== 8'h10) begin bad++; $display("FAIL both_full_q got=%h want=10", q); end
      for (int i = 1; i < DEPTH; i++) begin
         step(1'b0, 1'b1, 1'b0, 8'h00);
         total++; if (q !== DW'(8'h10 + i)) begin bad++; $display("FAIL both_drain i=%0d got=%h want=%h", i, q, DW'(8'h10 + i)); end
      end
      step(1'b1, 1'b1, 1'b0, 8'h77);
      total++; if (usedw !== 5'd1) begin bad++; $display("FAIL both_empty_usedw got=%0d want=1", usedw); end
      total++; if (flags !== 6'b001001) begin bad++; $display("FAIL both_empty_flags got=%b want=001001", flags); end
      total++; if (q !== 8'h1F) begin bad++; $display("FAIL both_empty_q got=%h want=1f", q); end
      step(1'b0, 1'b1, 1'b0, 8'h00);
      total++; if (q !== 8'h77) begin bad++; $display("FAIL both_empty_read got=%h want=77", q); end
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 1'b0, 1'b0, DW'(8'h40 + k));
         lq.push_back(DW'(8'h40 + k));
      end
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b1, 1'b0, DW'(8'h80 + i));
         want = lq.pop_front();
         lq.push_back(DW'(8'h80 + i));
         total++; if (q !== want) begin bad++; $display("FAIL both_mid_q i=%0d got=%h want=%h", i, q, want); end
         total++; if (usedw !== 5'd8) begin bad++; $display("FAIL both_mid_usedw i=%0d got=%0d want=8", i, usedw); end
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 1'b0, 8'h00);
         want = lq.pop_front();
         total++; if (q !== want) begin bad++; $display("FAIL both_tail_q i=%0d got=%h want=%h", i, q, want); end
      end
   endtask

   task automatic test_show_ahead();
      step(1'b1, 1'b0, 1'b0, 8'hA5);
      total++; if (q_sa !== 8'hA5) begin bad++; $display("FAIL sa_q got=%h want=a5", q_sa); end
      total++; if (empty_sa !== 1'b0) begin bad++; $display("FAIL sa_empty got=%b want=0", empty_sa); end
      step(1'b0, 1'b0, 1'b0, 8'h00);
      total++; if (q_sa !== 8'hA5) begin bad++; $display("FAIL sa_q_hold got=%h want=a5", q_sa); end
      step(1'b0, 1'b1, 1'b0, 8'h00);
      total++; if (empty_sa !== 1'b1) begin bad++; $display("FAIL sa_ack_empty got=%b want=1", empty_sa); end
      total++; if (usedw_sa !== 5'd0) begin bad++; $display("FAIL sa_ack_usedw got=%0d want=0", usedw_sa); end
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 9; k++) step(1'b1, 1'b0, 1'b0, DW'(8'h20 + k));
      step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'h29);
      total++; if (usedw !== 5'd9) begin bad++; $display("FAIL arst_pre_usedw got=%0d want=9", usedw); end
      wrreq = 1'b1; data = 8'h5A;
      #2 rst = 1'b1;
      #1;
      total++; if (usedw !== 5'd0) begin bad++; $display("FAIL arst_usedw got=%0d want=0", usedw); end
      total++; if (flags !== 6'b101000) begin bad++; $display("FAIL arst_flags got=%b want=101000", flags); end
      total++; if (q !== 8'h00) begin bad++; $display("FAIL arst_q got=%h want=00", q); end
      wrreq = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      step(1'b1, 1'b0, 1'b0, 8'h3C);
      total++; if (usedw !== 5'd1) begin bad++; $display("FAIL arst_first_wr got=%0d want=1", usedw); end
      step(1'b0, 1'b1, 1'b0, 8'h00);
      total++; if (q !== 8'h3C) begin bad++; $display("FAIL arst_first_rd got=%h want=3c", q); end
   endtask

   task automatic test_sclr();
      for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, DW'(8'h60 + k));
      step(1'b1, 1'b0, 1'b1, 8'hDD);
      total++; if (usedw !== 5'd0) begin bad++; $display("FAIL sclr_usedw got=%0d want=0", usedw); end
      total++; if (flags !== 6'b101000) begin bad++; $display("FAIL sclr_flags got=%b want=101000", flags); end
      total++; if (q !== 8'h00) begin bad++; $display("FAIL sclr_q got=%h want=00", q); end
      step(1'b1, 1'b0, 1'b0, 8'hC3);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      total++; if (q !== 8'hC3) begin bad++; $display("FAIL sclr_after_q got=%h want=c3", q); end
      total++; if (usedw !== 5'd0) begin bad++; $display("FAIL sclr_after_usedw got=%0d want=0", usedw); end
   endtask

   task automatic test_random();
      int n;
      int wp, rp;
      logic [5:0] want;
      for (int i = 0; i < 10000; i++) begin
         case ((i / 400) % 3)
            0: begin wp = 80; rp = 30; end
            1: begin wp = 30; rp = 80; end
            default: begin wp = 60; rp = 60; end
         endcase
         step(1'($urandom_range(0, 99) < wp), 1'($urandom_range(0, 99) < rp),
              1'($urandom_range(0, 499) == 0), DW'($urandom));
         n = exp_q.size();
         want = flags_for(n, ovf_exp, udf_exp);
         total++; if (int'(usedw) !== n) begin bad++; $display("FAIL rnd_usedw cyc=%0d got=%0d want=%0d", i, usedw, n); end
         total++; if (flags !== want) begin bad++; $display("FAIL rnd_flags cyc=%0d got=%b want=%b", i, flags, want); end
         total++; if (q !== q_exp) begin bad++; $display("FAIL rnd_q cyc=%0d got=%h want=%h", i, q, q_exp); end
         total++; if (flags_sa !== want) begin bad++; $display("FAIL rnd_flags_sa cyc=%0d got=%b want=%b", i, flags_sa, want); end
         if (n > 0) begin
            total++; if (q_sa !== exp_q[0]) begin bad++; $display("FAIL rnd_q_sa cyc=%0d got=%h want=%h", i, q_sa, exp_q[0]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow_underflow();
      test_simultaneous();
      test_show_ahead();
      test_async_reset();
      test_sclr();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
